bnn_layer_sequencer: RTL
========================

// Module: bnn_layer_sequencer
// PURPOSE
//  Central controller for the binary-NN MNIST classifier datapath. Accepts a 28x28 image handshake and weight writes,
//  then drives per-op commands through conv1 -> conv2 -> fc and argmaxes the 10 streamed fc scores into a 4-bit
//  class on a valid/ready output. Sits between top-level ports and layer engines/weight memories inside top.
// PARAMETERS
//  bW     8     kernel_offset / weight data width
//  N_C1   2304  conv1 ops per image (filters x out rows x out cols)
//  N_C2   768   conv2 ops per image
//  N_FC   9600  fc ops per image (fI=960 inputs x 10 classes)
//  SW     17    signed fc score width
//  IW     14    op index width; must hold max(N_C1,N_C2,N_FC)-1
// PORTS
//  clk              in   1    clock, all logic on rising edge
//  rst              in   1    synchronous active-high reset
//  image_in_valid   in   1    image present on top-level image bus
//  image_in_ready   out  1    image accepted when valid&ready
//  img_load_en      out  1    1-cycle pulse: datapath captures image bus
//  kernel_in_valid  in   1    weight write request
//  kernel_in_ready  out  1    weight write accepted when valid&ready
//  kernel_layer     in   2    1=conv1, 2=conv2, 3=fc; 0 illegal
//  kernel_addr      in   11   weight address
//  kernel_offset    in   bW   weight data
//  wt_wr_en         out  3    one-hot write enable {fc,conv2,conv1}
//  wt_wr_addr       out  11   registered kernel_addr
//  wt_wr_data       out  bW   registered kernel_offset
//  kernel_err       out  1    sticky: write with kernel_layer==0 seen
//  dp_op_valid      out  1    op command valid to layer engines
//  dp_stall         in   1    engines cannot take op this cycle
//  dp_layer         out  2    layer of current op (1..3)
//  dp_idx           out  IW   op index within layer
//  dp_last          out  1    current op is last of its layer
//  fc_score_valid   in   1    one fc class score this cycle, in class order 0..9
//  fc_score         in   SW   signed score
//  class_out_valid  out  1    class result valid
//  class_out_ready  in   1    consumer accepts result
//  class_out        out  4    winning class 0..9
//  busy             out  1    state != IDLE
// BEHAVIOUR
//  FSM: IDLE -> C1 -> C2 -> FC -> ARGMAX -> OUT -> IDLE.
//  Reset (rst high at edge): state IDLE; counters, max, class_out, wt_wr_*, kernel_err cleared. While rst is high,
//   all outputs are 0, including readies. rst mid-operation aborts the image: no class_out produced.
//  IDLE: kernel_in_ready=1; image_in_ready = !kernel_in_valid (weight write wins a simultaneous request).
//   Write accept: next cycle wt_wr_en one-hot for 1 cycle by kernel_layer, addr/data registered; layer 0 -> no
//   enable, kernel_err<=1. Image accept: img_load_en=1 same cycle, next state C1, dp_idx=0.
//  Outside IDLE: kernel_in_ready=0, image_in_ready=0; requests are held off, never dropped.
//  C1/C2/FC: dp_op_valid=1, dp_layer=1/2/3. On !dp_stall, dp_idx++. dp_last = (dp_idx==N-1). An accepted last op
//   moves to the next layer with idx 0 the following cycle (no bubble). FC last accepted -> ARGMAX.
//  dp_stall holds dp_idx/dp_layer/dp_op_valid stable.
//  Scores counted in FC and ARGMAX only (elsewhere ignored). The 4-bit count saturates at 10; extras are ignored.
//   Signed compare; strictly greater replaces max, so a tie keeps the lowest index. First score always loads.
//  ARGMAX: dp_op_valid=0; when count==10 -> OUT; class_out=argmax, class_out_valid=1.
//  OUT: valid and class held until class_out_ready; handshake -> IDLE next cycle, count/max cleared.
//  Latency with no stalls: image accept to 1st op = 1 cycle; N_C1+N_C2+N_FC op cycles.
// TESTING (bench overrides N_C1=4, N_C2=3, N_FC=5)
//  1 IDLE write layer=2 addr=17 off=0x5A -> next cycle wt_wr_en=3'b010, addr=17, data=0x5A; layer=0 -> wt_wr_en=0,
//    kernel_err=1 and stays set.
//  2 image accepted, no stall -> dp (layer,idx): (1,0..3),(2,0..2),(3,0..4) on 12 consecutive cycles; dp_last on
//    idx 3,2,4; busy=1.
//  3 dp_stall=1 for 3 cycles at (2,1) -> outputs frozen at (2,1); stream resumes; FC ends 3 cycles later.
//  4 scores 5,-3,9,9,0,-1,2,8,9,-20 -> class_out=2; class_out_ready low 4 cycles -> valid/class held; ready -> IDLE.
//  5 image_in_valid & kernel_in_valid same IDLE cycle -> write done, image_in_ready=0; image accepted next cycle.
//  6 rst high 1 cycle at (2,1) -> IDLE next cycle, dp_op_valid=0, busy=0, no class_out_valid; new image runs clean.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: image/weight intake, conv1->conv2->fc op sequencing and fc-score argmax.
module bnn_layer_sequencer #(
  parameter int bW   = 8,
  parameter int N_C1 = 2304,
  parameter int N_C2 = 768,
  parameter int N_FC = 9600,
  parameter int SW   = 17,
  parameter int IW   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 image_in_valid,
  output logic                 image_in_ready,
  output logic                 img_load_en,
  input  logic                 kernel_in_valid,
  output logic                 kernel_in_ready,
  input  logic [1:0]           kernel_layer,
  input  logic [10:0]          kernel_addr,
  input  logic [bW-1:0]        kernel_offset,
  output logic [2:0]           wt_wr_en,
  output logic [10:0]          wt_wr_addr,
  output logic [bW-1:0]        wt_wr_data,
  output logic                 kernel_err,
  output logic                 dp_op_valid,
  input  logic                 dp_stall,
  output logic [1:0]           dp_layer,
  output logic [IW-1:0]        dp_idx,
  output logic                 dp_last,
  input  logic                 fc_score_valid,
  input  logic signed [SW-1:0] fc_score,
  output logic                 class_out_valid,
  input  logic                 class_out_ready,
  output logic [3:0]           class_out,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, C1, C2, FC, ARGMAX, OUT} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [3:0] cnt, arg, class_q;
  logic signed [SW-1:0] max_q;
  logic [2:0] wr_en_q;
  logic [10:0] addr_q;
  logic [bW-1:0] data_q;
  logic err_q, idle, wr_acc, img_acc, score_take;
  logic [IW-1:0] n_last;
  assign idle = !rst && state == IDLE;
  assign kernel_in_ready = idle;
  assign image_in_ready = idle && !kernel_in_valid;
  assign wr_acc = kernel_in_valid && kernel_in_ready;
  assign img_acc = image_in_valid && image_in_ready;
  assign img_load_en = img_acc;
  assign dp_op_valid = !rst && (state == C1 || state == C2 || state == FC);
  assign dp_layer = dp_op_valid ? 2'(state) : 2'd0;
  assign dp_idx = dp_op_valid ? idx : '0;
  assign n_last = state == C1 ? IW'(N_C1 - 1) : state == C2 ? IW'(N_C2 - 1) : IW'(N_FC - 1);
  assign dp_last = dp_op_valid && idx == n_last;
  // Score count saturates at 10 so stray extra scores cannot disturb the result.
  assign score_take = !rst && (state == FC || state == ARGMAX) && fc_score_valid && cnt < 4'd10;
  assign class_out_valid = !rst && state == OUT;
  assign class_out = rst ? 4'd0 : class_q;
  assign wt_wr_en = rst ? 3'd0 : wr_en_q;
  assign wt_wr_addr = rst ? 11'd0 : addr_q;
  assign wt_wr_data = rst ? '0 : data_q;
  assign kernel_err = !rst && err_q;
  assign busy = !rst && state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      arg <= '0;
      max_q <= '0;
      class_q <= '0;
      wr_en_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_en_q <= '0;
      if (wr_acc) begin
        wr_en_q <= kernel_layer == 2'd0 ? 3'b000 : 3'b001 << (kernel_layer - 2'd1);
        addr_q <= kernel_addr;
        data_q <= kernel_offset;
        if (kernel_layer == 2'd0) err_q <= 1'b1;
      end
      if (score_take) begin
        if (cnt == 4'd0 || fc_score > max_q) begin
          max_q <= fc_score;
          arg <= cnt;
        end
        cnt <= cnt + 4'd1;
      end
      case (state)
        IDLE: if (img_acc) begin
          state <= C1;
          idx <= '0;
        end
        C1, C2, FC: if (!dp_stall) begin
          idx <= dp_last ? '0 : idx + IW'(1);
          if (dp_last) state <= state == C1 ? C2 : state == C2 ? FC : ARGMAX;
        end
        ARGMAX: if (cnt == 4'd10) begin
          state <= OUT;
          class_q <= arg;
        end
        OUT: if (class_out_ready) begin
          state <= IDLE;
          cnt <= '0;
          max_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
